encaixotador_garrafas: RTL and testbench

- Downstream stage of the bottling line; consumes sealed and counted bottles from the process FSM, one bottle per valid/ready transfer.
- Packs bottles into a box of GARRAFAS_POR_CAIXA and drives the box conveyor motor to ship a full box and bring an empty one.
- Counts shipped boxes up to a pallet limit and back-pressures the upstream line while no box is in position.
- Clocked on the same slow clock as the process and motor FSMs.

---
 rtl/encaixotador_garrafas_pkg.sv | 19 +
 rtl/encaixotador_garrafas_contador_caixa_mod.sv | 26 ++
 rtl/encaixotador_garrafas.sv | 121 ++++++++++++
 tb/tb_encaixotador_garrafas.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/encaixotador_garrafas_pkg.sv
// Shared types and defaults for the box packer: state encoding, limits, counter widths.
package encaixotador_pkg;

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    AGUARDA_CAIXA = 3'd1,
    ENCHENDO      = 3'd2,
    EXPEDINDO     = 3'd3,
    PALETE_CHEIO  = 3'd4,
    FALHA         = 3'd5
  } estado_t;

  localparam int GARRAFAS_DEFAULT = 12;
  localparam int CAIXAS_DEFAULT   = 10;
  localparam int TIMEOUT_DEFAULT  = 8;
  localparam int CONT_W           = 4;
  localparam int WD_W             = 4;

endpackage

// File: rtl/encaixotador_garrafas_contador_caixa_mod.sv
// Modulo-N up-counter with increment enable, synchronous clear and terminal-count flag.
module contador_caixa_mod #(
  parameter int N = 12,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/encaixotador_garrafas.sv
// Bottle box packer: fills boxes from a valid/ready stream, ships them, counts a pallet.
// Optional box-motion watchdog enabled by defining ENCAIXOTADOR_TIMEOUT_EN.
//
// state         | meaning
// OCIOSO        | idle, waiting for start
// AGUARDA_CAIXA | conveyor bringing an empty box
// ENCHENDO      | box in position, accepting bottles
// EXPEDINDO     | conveyor shipping the full box
// PALETE_CHEIO  | pallet complete, halted until start
// FALHA         | box motion timed out, held until reset
module encaixotador_garrafas
  import encaixotador_pkg::*;
#(
`ifdef ENCAIXOTADOR_TIMEOUT_EN
  parameter int CICLOS_TIMEOUT     = TIMEOUT_DEFAULT,
`endif
  parameter int GARRAFAS_POR_CAIXA = GARRAFAS_DEFAULT,
  parameter int CAIXAS_POR_PALETE  = CAIXAS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              garrafa_valid,
  output logic              pronto_receber,
  input  logic              sensor_caixa_posicao,
  input  logic              sensor_caixa_saida,
  output logic              motor_caixa,
  output logic [CONT_W-1:0] garrafas_na_caixa,
  output logic [CONT_W-1:0] contagem_caixas,
  output logic              caixa_completa,
  output logic              palete_cheio,
  output logic              led_alarme_caixa
);

  estado_t state_q, state_d;
  logic    pronto_q, completa_q;
  logic    transfer, ultima, limpa_caixas;
  logic    tc_garrafa, tc_caixa;
  logic    em_movimento;

  assign transfer     = garrafa_valid & pronto_q & (state_q == ENCHENDO);
  assign ultima       = transfer & tc_garrafa;
  assign limpa_caixas = start & (state_q == PALETE_CHEIO);
  assign em_movimento = (state_q == AGUARDA_CAIXA) | (state_q == EXPEDINDO);

  contador_caixa_mod #(.N(GARRAFAS_POR_CAIXA), .W(CONT_W)) u_garrafas (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == OCIOSO),
    .inc   (transfer),
    .count (garrafas_na_caixa),
    .tc    (tc_garrafa)
  );

  // One extra step so the count can sit at the pallet limit instead of wrapping.
  contador_caixa_mod #(.N(CAIXAS_POR_PALETE + 1), .W(CONT_W)) u_caixas (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (limpa_caixas),
    .inc   (ultima),
    .count (contagem_caixas),
    .tc    (tc_caixa)
  );

`ifdef ENCAIXOTADOR_TIMEOUT_EN
  logic [WD_W-1:0] wd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if (state_d != state_q) begin
      wd_q <= '0;
    end else if (em_movimento) begin
      wd_q <= wd_q + 1'b1;
    end else begin
      wd_q <= '0;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      OCIOSO:        if (start) state_d = AGUARDA_CAIXA;
      AGUARDA_CAIXA: if (sensor_caixa_posicao) state_d = ENCHENDO;
      ENCHENDO:      if (ultima) state_d = EXPEDINDO;
      EXPEDINDO:     if (sensor_caixa_saida) state_d = tc_caixa ? PALETE_CHEIO : AGUARDA_CAIXA;
      PALETE_CHEIO:  if (start) state_d = AGUARDA_CAIXA;
      FALHA:         state_d = FALHA;
      default:       state_d = OCIOSO;
    endcase
`ifdef ENCAIXOTADOR_TIMEOUT_EN
    if (em_movimento && (state_d == state_q) && (wd_q == WD_W'(CICLOS_TIMEOUT - 1)))
      state_d = FALHA;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OCIOSO;
      pronto_q   <= 1'b0;
      completa_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pronto_q   <= (state_d == ENCHENDO) & sensor_caixa_posicao;
      completa_q <= ultima;
    end
  end

  assign pronto_receber = pronto_q;
  assign caixa_completa = completa_q;
  assign motor_caixa    = em_movimento;
  assign palete_cheio   = (state_q == PALETE_CHEIO);

`ifdef ENCAIXOTADOR_TIMEOUT_EN
  assign led_alarme_caixa = (state_q == FALHA);
`else
  assign led_alarme_caixa = (state_q == AGUARDA_CAIXA) & garrafa_valid;
`endif

endmodule

// File: tb/tb_encaixotador_garrafas.sv
// Directed bench for the box packer: fill, stall, pallet, async reset, optional watchdog.
module tb_encaixotador_garrafas;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       garrafa_valid;
  logic       pronto_receber;
  logic       sensor_caixa_posicao;
  logic       sensor_caixa_saida;
  logic       motor_caixa;
  logic [3:0] garrafas_na_caixa;
  logic [3:0] contagem_caixas;
  logic       caixa_completa;
  logic       palete_cheio;
  logic       led_alarme_caixa;

  int checks = 0;
  int errors = 0;

  encaixotador_garrafas #(
    .GARRAFAS_POR_CAIXA (12),
    .CAIXAS_POR_PALETE  (2)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .garrafa_valid        (garrafa_valid),
    .pronto_receber       (pronto_receber),
    .sensor_caixa_posicao (sensor_caixa_posicao),
    .sensor_caixa_saida   (sensor_caixa_saida),
    .motor_caixa          (motor_caixa),
    .garrafas_na_caixa    (garrafas_na_caixa),
    .contagem_caixas      (contagem_caixas),
    .caixa_completa       (caixa_completa),
    .palete_cheio         (palete_cheio),
    .led_alarme_caixa     (led_alarme_caixa)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, "_motor"}, motor_caixa, 1'b0);
    check1({tag, "_pronto"}, pronto_receber, 1'b0);
    check4({tag, "_garrafas"}, garrafas_na_caixa, 4'd0);
    check4({tag, "_caixas"}, contagem_caixas, 4'd0);
    check1({tag, "_completa"}, caixa_completa, 1'b0);
    check1({tag, "_palete"}, palete_cheio, 1'b0);
    check1({tag, "_led"}, led_alarme_caixa, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    garrafa_valid = 1'b0;
    sensor_caixa_posicao = 1'b0;
    sensor_caixa_saida = 1'b0;
    #3;
    check_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check1("idle_motor", motor_caixa, 1'b0);

    // arm, box absent for 3 cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check1("wait_motor", motor_caixa, 1'b1);
    check1("wait_pronto", pronto_receber, 1'b0);
`ifndef ENCAIXOTADOR_TIMEOUT_EN
    garrafa_valid = 1'b1;
    #1;
    check1("wait_led", led_alarme_caixa, 1'b1);
    garrafa_valid = 1'b0;
    #1;
`endif
    sensor_caixa_posicao = 1'b1;
    tick();
    check1("inpos_motor", motor_caixa, 1'b0);
    check1("inpos_pronto", pronto_receber, 1'b1);

    // 12 back-to-back bottles
    garrafa_valid = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check4("fill1_count", garrafas_na_caixa, 4'(i % 12));
      if (i < 12) check1("fill1_nopulse", caixa_completa, 1'b0);
    end
    check1("box1_pulse", caixa_completa, 1'b1);
    check4("box1_caixas", contagem_caixas, 4'd1);
    check1("box1_pronto", pronto_receber, 1'b0);
    check1("box1_motor", motor_caixa, 1'b1);
    tick();
    check4("no13_count", garrafas_na_caixa, 4'd0);
    check1("no13_pulse", caixa_completa, 1'b0);
    check1("no13_pronto", pronto_receber, 1'b0);
    garrafa_valid = 1'b0;

    // ship box 1, bring box 2
    sensor_caixa_posicao = 1'b0;
    sensor_caixa_saida = 1'b1;
    tick();
    sensor_caixa_saida = 1'b0;
    check1("ret_motor", motor_caixa, 1'b1);
    check1("ret_palete", palete_cheio, 1'b0);
    sensor_caixa_posicao = 1'b1;
    tick();
    check1("box2_pronto", pronto_receber, 1'b1);

    // 5 bottles then lose the box
    garrafa_valid = 1'b1;
    for (int i = 1; i <= 5; i++) tick();
    check4("five_count", garrafas_na_caixa, 4'd5);
    garrafa_valid = 1'b0;
    sensor_caixa_posicao = 1'b0;
    tick();
    check1("lost_pronto", pronto_receber, 1'b0);
    garrafa_valid = 1'b1;
    tick();
    tick();
    check4("lost_count", garrafas_na_caixa, 4'd5);
    check1("lost_pronto2", pronto_receber, 1'b0);
    sensor_caixa_posicao = 1'b1;
    tick();
    check1("back_pronto", pronto_receber, 1'b1);
    check4("back_count", garrafas_na_caixa, 4'd5);
    tick();
    check4("resume_count", garrafas_na_caixa, 4'd6);
    for (int i = 7; i <= 12; i++) tick();
    check4("box2_count", garrafas_na_caixa, 4'd0);
    check1("box2_pulse", caixa_completa, 1'b1);
    check4("box2_caixas", contagem_caixas, 4'd2);
    garrafa_valid = 1'b0;

    // ship box 2 -> pallet full
    sensor_caixa_posicao = 1'b0;
    sensor_caixa_saida = 1'b1;
    tick();
    sensor_caixa_saida = 1'b0;
    check1("pal_flag", palete_cheio, 1'b1);
    check1("pal_motor", motor_caixa, 1'b0);
    check4("pal_caixas", contagem_caixas, 4'd2);
    garrafa_valid = 1'b1;
    sensor_caixa_posicao = 1'b1;
    tick();
    tick();
    check1("pal_stall_pronto", pronto_receber, 1'b0);
    check1("pal_hold", palete_cheio, 1'b1);
    garrafa_valid = 1'b0;
    sensor_caixa_posicao = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check4("clr_caixas", contagem_caixas, 4'd0);
    check1("clr_palete", palete_cheio, 1'b0);
    check1("clr_motor", motor_caixa, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check1("start_ignored_motor", motor_caixa, 1'b1);
    check1("start_ignored_pronto", pronto_receber, 1'b0);

    // partial box then asynchronous reset
    sensor_caixa_posicao = 1'b1;
    tick();
    garrafa_valid = 1'b1;
    for (int i = 1; i <= 7; i++) tick();
    check4("mid_count", garrafas_na_caixa, 4'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    garrafa_valid = 1'b0;
    sensor_caixa_posicao = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_all_zero("post_rst");

`ifdef ENCAIXOTADOR_TIMEOUT_EN
    start = 1'b1;
    tick();
    start = 1'b0;
    sensor_caixa_posicao = 1'b1;
    tick();
    garrafa_valid = 1'b1;
    for (int i = 1; i <= 12; i++) tick();
    garrafa_valid = 1'b0;
    sensor_caixa_posicao = 1'b0;
    check1("wd_ship_motor", motor_caixa, 1'b1);
    for (int i = 1; i <= 7; i++) tick();
    check1("wd_pre_led", led_alarme_caixa, 1'b0);
    check1("wd_pre_motor", motor_caixa, 1'b1);
    tick();
    check1("wd_led", led_alarme_caixa, 1'b1);
    check1("wd_motor", motor_caixa, 1'b0);
    check1("wd_pronto", pronto_receber, 1'b0);
    sensor_caixa_saida = 1'b1;
    start = 1'b1;
    tick();
    tick();
    sensor_caixa_saida = 1'b0;
    start = 1'b0;
    check1("wd_stuck_led", led_alarme_caixa, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("wd_rst_led", led_alarme_caixa, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
